// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider:
//   DIV_WIDTH_DEFAULT : default operand/result width in bits
//   div_state_t       : controller states (IDLE, RUN, FIX, DONE)
//   div_count_width() : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_t;

   // The counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
   function automatic int div_count_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring shift / trial-subtract / restore step of unsigned division.
// Purely combinational so it can be checked on its own or replicated for a
// higher-radix version.
//
// Ports:
//   r      in  WIDTH  current partial remainder
//   q      in  WIDTH  quotient shift register (undivided dividend bits on top)
//   d      in  WIDTH  divisor magnitude
//   r_next out WIDTH  partial remainder after the step
//   q_next out WIDTH  quotient register after the step (new bit in LSB)
// -----------------------------------------------------------------------------
module div_step
#(
   parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] r_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH-1:0] r_shift;
   logic [WIDTH:0]   trial;
   logic             no_borrow;

   // After i steps the remainder is below 2^i and is always below the divisor,
   // so entering any step its MSB is zero and shifting it out loses nothing.
   logic unused_r_msb;
   assign unused_r_msb = r[WIDTH-1];

   // NOTE: every output of an always_comb block is assigned on every path;
   // a path that skips an assignment would infer a latch.
   always_comb begin
      r_shift   = {r[WIDTH-2:0], q[WIDTH-1]};
      // Same A + ~B + 1 form as the adder path; the carry out of bit WIDTH
      // is set exactly when r_shift >= d (no borrow).
      trial     = {1'b0, r_shift} + {1'b0, ~d} + {{WIDTH{1'b0}}, 1'b1};
      no_borrow = trial[WIDTH];
      r_next    = no_borrow ? trial[WIDTH-1:0] : r_shift;
      q_next    = {q[WIDTH-2:0], no_borrow};
   end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative WIDTH-bit integer divider, one restoring step per cycle, signed or
// unsigned, with a start/done handshake. Signed operands are divided as
// magnitudes and the signs are applied in a single fix-up cycle.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   start       in   1      request, accepted in IDLE or DONE only
//   signed_op   in   1      1 = two's-complement operands (sampled with start)
//   dividend    in   WIDTH  numerator (sampled with start)
//   divisor     in   WIDTH  denominator (sampled with start)
//   busy        out  1      high while iterating or fixing up signs
//   done        out  1      one-cycle pulse, results valid from this cycle on
//   quotient    out  WIDTH  result quotient (held until the next completion)
//   remainder   out  WIDTH  result remainder (held until the next completion)
//   div_by_zero out  1      divisor was zero; held with the results
// -----------------------------------------------------------------------------
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = div_count_width(WIDTH);

   div_state_t       state;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic             neg_q;
   logic             neg_r;
   logic [CNT_W-1:0] count;

   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] q_step;

   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;

   // Sign bits only mean "negative" for signed operations; unsigned operands
   // with the MSB set are plain magnitudes.
   assign dividend_neg = signed_op & dividend[WIDTH-1];
   assign divisor_neg  = signed_op & divisor[WIDTH-1];

   // The magnitude of MIN is 2^(WIDTH-1), which still fits as an unsigned
   // value, so MIN / -1 comes out as quotient MIN without a special case.
   assign dividend_mag = dividend_neg ? (~dividend + WIDTH'(1)) : dividend;
   assign divisor_mag  = divisor_neg  ? (~divisor  + WIDTH'(1)) : divisor;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_reg),
      .q      (q_reg),
      .d      (d_reg),
      .r_next (r_step),
      .q_next (q_step)
   );

   assign busy = (state == ST_RUN) || (state == ST_FIX);
   assign done = (state == ST_DONE);

   // NOTE: state registers use non-blocking assignments so every register in
   // this block samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         r_reg       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (divisor == '0) begin
                     // No iteration: results are defined directly and the
                     // raw dividend is returned unmodified.
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     q_reg <= dividend_mag;
                     d_reg <= divisor_mag;
                     r_reg <= '0;
                     neg_q <= dividend_neg ^ divisor_neg;
                     neg_r <= dividend_neg;
                     count <= CNT_W'(WIDTH - 1);
                     state <= ST_RUN;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_RUN: begin
               r_reg <= r_step;
               q_reg <= q_step;
               if (count == '0) begin
                  state <= ST_FIX;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end

            ST_FIX: begin
               // Outputs are only written here and on a divide-by-zero
               // accept, so partial results never appear on the ports.
               quotient    <= neg_q ? (~q_reg + WIDTH'(1)) : q_reg;
               remainder   <= neg_r ? (~r_reg + WIDTH'(1)) : r_reg;
               div_by_zero <= 1'b0;
               state       <= ST_DONE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed vectors for seq_divider. Each accepted request pushes its expected
// quotient/remainder/div_by_zero and completion cycle into a queue; a monitor
// pops and compares whenever done is high.
// Cycle numbering: cycle 0 is the cycle in which start is presented.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int W = 32;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         start     = 1'b0;
   logic         signed_op = 1'b0;
   logic [W-1:0] dividend  = '0;
   logic [W-1:0] divisor   = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           cyc;
   } exp_t;

   exp_t sb[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", W'(done), W'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient",    quotient,       e.q);
            check("remainder",   remainder,      e.r);
            check("div_by_zero", W'(div_by_zero), W'(e.dbz));
            check("done_cycle",  W'(cyc),        W'(e.cyc));
         end
      end
   end

   // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
   task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic expect_it, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edbz);
      exp_t e;
      if (expect_it) begin
         e.q   = eq;
         e.r   = er;
         e.dbz = edbz;
         e.cyc = cyc + ((b == '0) ? 1 : W + 2);
         sb.push_back(e);
      end
      signed_op = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Waits (bounded) for done, counting busy cycles and optionally checking
   // that the previous results stay on the outputs. Returns in the done cycle.
   task automatic wait_done(input int ebusy, input logic hold_chk,
                            input logic [W-1:0] hq, input logic [W-1:0] hr,
                            input string tag);
      int   n;
      int   bcnt;
      logic hold_ok;
      n       = 0;
      bcnt    = 0;
      hold_ok = 1'b1;
      while (done !== 1'b1 && n < 200) begin
         if (busy === 1'b1) bcnt++;
         if (hold_chk && (quotient !== hq || remainder !== hr)) hold_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"},    W'(done), W'(1));
      check({tag, "_busy_at_done"}, W'(busy), W'(0));
      if (ebusy >= 0) check({tag, "_busy_cycles"}, W'(bcnt), W'(ebusy));
      if (hold_chk)   check({tag, "_hold"},        W'(hold_ok), W'(1));
   endtask

   initial begin
      int dones;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy",  W'(busy),        W'(0));
      check("rst_done",  W'(done),        W'(0));
      check("rst_quot",  quotient,        W'(0));
      check("rst_rem",   remainder,       W'(0));
      check("rst_dbz",   W'(div_by_zero), W'(0));

      // Unsigned 100/7 = 14 r 2
      issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
      wait_done(33, 1'b0, '0, '0, "u100_7");
      @(negedge clk);

      // Signed -100/7 = -14 r -2
      issue(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      wait_done(33, 1'b0, '0, '0, "s_m100_7");
      @(negedge clk);

      // Unsigned 4294967196/7: 7*0x24924924 = 2^32-4, so the quotient is
      // 0x24924924-14 = 0x24924916 and 7*0x24924916 = 0xFFFFFF9A, remainder 2.
      issue(1'b0, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'h2492_4916, 32'd2, 1'b0);
      wait_done(33, 1'b0, '0, '0, "u_big_7");
      @(negedge clk);

      // Signed 100/-7 = -14 r 2
      issue(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);
      wait_done(33, 1'b0, '0, '0, "s_100_m7");
      @(negedge clk);

      // Signed -100/-7 = 14 r -2
      issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0);
      wait_done(33, 1'b0, '0, '0, "s_m100_m7");
      @(negedge clk);

      // Signed overflow MIN / -1 = MIN r 0, no divide-by-zero flag
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
      wait_done(33, 1'b0, '0, '0, "s_min_m1");
      @(negedge clk);

      // Unsigned all-ones / all-ones = 1 r 0
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd1, 32'd0, 1'b0);
      wait_done(33, 1'b0, '0, '0, "u_max_max");
      @(negedge clk);

      // Unsigned 7/100 = 0 r 7
      issue(1'b0, 32'd7, 32'd100, 1'b1, 32'd0, 32'd7, 1'b0);
      wait_done(33, 1'b0, '0, '0, "u7_100");
      @(negedge clk);

      // Divide by zero, signed and unsigned
      issue(1'b1, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
      wait_done(0, 1'b0, '0, '0, "s5_0");
      @(negedge clk);
      issue(1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
      wait_done(0, 1'b0, '0, '0, "u5_0");
      @(negedge clk);
      // Negative dividend comes back unmodified
      issue(1'b1, 32'hFFFF_FF9C, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
      wait_done(0, 1'b0, '0, '0, "s_m100_0");
      @(negedge clk);

      // A start during RUN (cycle 5) is ignored; a divisor of zero there
      // would show up as an early done with the flag set.
      issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
      repeat (4) @(negedge clk);
      signed_op = 1'b1;
      dividend  = 32'd1000;
      divisor   = 32'd0;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      wait_done(-1, 1'b0, '0, '0, "ignore_start");
      @(negedge clk);

      // Back-to-back: start 255/16 in the DONE cycle of 100/7
      issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
      wait_done(33, 1'b0, '0, '0, "b2b_first");
      issue(1'b0, 32'd255, 32'd16, 1'b1, 32'd15, 32'd15, 1'b0);
      wait_done(33, 1'b1, 32'd14, 32'd2, "b2b_second");
      @(negedge clk);

      // Reset at cycle 10 of a divide: everything clears, no done follows
      issue(1'b0, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", W'(busy),        W'(0));
      check("midrst_done", W'(done),        W'(0));
      check("midrst_quot", quotient,        W'(0));
      check("midrst_rem",  remainder,       W'(0));
      check("midrst_dbz",  W'(div_by_zero), W'(0));
      rst   = 1'b0;
      dones = 0;
      repeat (50) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("midrst_no_done", W'(dones), W'(0));

      check("scoreboard_empty", W'(sb.size()), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
